// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC input stage: mode encoding, quadrant
// type and a saturating two's-complement negate helper.
package cordic_pkg;

  typedef enum logic {
    MODE_ROTATION  = 1'b0,
    MODE_VECTORING = 1'b1
  } cordic_mode_e;

  typedef logic [1:0] cordic_quad_t;

  localparam cordic_quad_t QUAD_0 = 2'd0;
  localparam cordic_quad_t QUAD_1 = 2'd1;
  localparam cordic_quad_t QUAD_2 = 2'd2;
  localparam cordic_quad_t QUAD_3 = 2'd3;

  // Negates a sign-extended value of the given width; the most negative
  // value maps to the most positive one instead of wrapping onto itself.
  function automatic logic [63:0] sat_neg(input logic [63:0] value, input int unsigned width);
    logic [63:0] minVal;
    logic [63:0] result;
    minVal = 64'hFFFF_FFFF_FFFF_FFFF << (width - 1);
    if (value == minVal) begin
      result = ~minVal;
    end else begin
      result = 64'd0 - value;
    end
    return result;
  endfunction

endpackage

// File: rtl/cordic_req_fifo.sv
// Two-entry request FIFO with registered full/empty flags. An entry written
// on one edge only becomes visible to a pop on a later edge (no bypass).
module cordic_req_fifo
  import cordic_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [1:0]        countNext_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wrPtr_q;
  logic              rdPtr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              full_q;
  logic              empty_q;
  logic              doPush;
  logic              doPop;

  assign doPush = push_i & ~full_q;
  assign doPop  = pop_i & ~empty_q;

  // Occupancy after this edge, shared with the parent for its ready flag.
  always_comb begin
    count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
  end

  // Storage, pointers and flags; flags are derived from the next count so
  // they are valid straight out of the flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
      full_q  <= (count_d == 2'd2);
      empty_q <= (count_d == 2'd0);
    end
  end

  assign data_o      = mem_q[rdPtr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign countNext_o = count_d;

endmodule

// File: rtl/cordic_input_stage.sv
// CORDIC input stage: buffers requests in a 2-entry FIFO and, when the
// pipeline advances, loads the quadrant-reduced request into the first-stage
// registers. Define CORDIC_QUAD_REDUCE_EN to enable quarter-turn pre-rotation;
// without it x/y pass through unchanged and the quadrant is always 0.
module cordic_input_stage
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BIT_WIDTH+1:0] req_angle,
  input  logic [BIT_WIDTH-1:0] req_x,
  input  logic [BIT_WIDTH-1:0] req_y,
  input  logic                 req_mode,
  input  logic                 start,
  output logic [BIT_WIDTH-1:0] out_target_angle,
  output logic [BIT_WIDTH:0]   out_current_angle,
  output logic [BIT_WIDTH-1:0] out_x,
  output logic [BIT_WIDTH-1:0] out_y,
  output logic                 out_mode,
  output logic                 out_done,
  output logic [1:0]           out_quadrant
);

  localparam int DATA_W = 3 * BIT_WIDTH + 3;

  logic [DATA_W-1:0]    pushData;
  logic [DATA_W-1:0]    headData;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic [1:0]           fifoCountNext;
  logic                 push;
  logic                 pop;

  logic                 headModeBit;
  cordic_mode_e         headMode;
  logic [BIT_WIDTH+1:0] headAngle;
  logic [BIT_WIDTH-1:0] headX;
  logic [BIT_WIDTH-1:0] headY;

  logic [BIT_WIDTH-1:0] redTarget;
  logic [BIT_WIDTH-1:0] redX;
  logic [BIT_WIDTH-1:0] redY;
  cordic_quad_t         redQuad;

  logic                 ready_q, ready_d;
  logic [BIT_WIDTH-1:0] target_q, target_d;
  logic [BIT_WIDTH-1:0] x_q, x_d;
  logic [BIT_WIDTH-1:0] y_q, y_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  cordic_quad_t         quad_q, quad_d;

  assign push     = req_valid & ready_q;
  assign pop      = start & ~fifoEmpty;
  assign pushData = {req_mode, req_angle, req_x, req_y};

  cordic_req_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .data_i      (pushData),
    .data_o      (headData),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty),
    .countNext_o (fifoCountNext)
  );

  assign {headModeBit, headAngle, headX, headY} = headData;
  assign headMode = cordic_mode_e'(headModeBit);

`ifdef CORDIC_QUAD_REDUCE_EN
  function automatic logic [BIT_WIDTH-1:0] negSat(input logic [BIT_WIDTH-1:0] v);
    return BIT_WIDTH'(sat_neg({{(64-BIT_WIDTH){v[BIT_WIDTH-1]}}, v}, BIT_WIDTH));
  endfunction

  // Pre-rotate the head request by whole quarter turns so the residual
  // angle (rotation) or the vector (vectoring) lands in the right half-plane.
  // Adding pi/4 before taking the top two bits is the same as adding the
  // bit just below the quadrant field into it.
  always_comb begin
    redX      = headX;
    redY      = headY;
    redTarget = '0;
    redQuad   = QUAD_0;
    if (headMode == MODE_ROTATION) begin
      redQuad   = headAngle[BIT_WIDTH+1:BIT_WIDTH] + {1'b0, headAngle[BIT_WIDTH-1]};
      redTarget = headAngle[BIT_WIDTH-1:0];
      case (redQuad)
        QUAD_1: begin
          redX = negSat(headY);
          redY = headX;
        end
        QUAD_2: begin
          redX = negSat(headX);
          redY = negSat(headY);
        end
        QUAD_3: begin
          redX = headY;
          redY = negSat(headX);
        end
        default: begin
          redX = headX;
          redY = headY;
        end
      endcase
    end else if (headX[BIT_WIDTH-1]) begin
      redX    = negSat(headX);
      redY    = negSat(headY);
      redQuad = QUAD_2;
    end
  end
`else
  logic unusedAngleHi;
  assign unusedAngleHi = ^headAngle[BIT_WIDTH+1:BIT_WIDTH];

  // No pre-rotation: the vector passes through and only rotation mode
  // carries a residual target angle.
  always_comb begin
    redX      = headX;
    redY      = headY;
    redQuad   = QUAD_0;
    redTarget = '0;
    if (headMode == MODE_ROTATION) begin
      redTarget = headAngle[BIT_WIDTH-1:0];
    end
  end
`endif

  // Next state of the first-stage registers: load on an advance with data,
  // flag a bubble on an advance without data, otherwise hold.
  always_comb begin
    ready_d  = (fifoCountNext != 2'd2);
    target_d = target_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    quad_d   = quad_q;
    done_d   = done_q;
    if (start) begin
      if (!fifoEmpty) begin
        target_d = redTarget;
        x_d      = redX;
        y_d      = redY;
        mode_d   = headModeBit;
        quad_d   = redQuad;
        done_d   = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end
  end

  // Output and ready registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      target_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 1'b0;
      quad_q   <= QUAD_0;
      done_q   <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      target_q <= target_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      quad_q   <= quad_d;
      done_q   <= done_d;
    end
  end

  assign req_ready         = ready_q;
  assign out_target_angle  = target_q;
  assign out_current_angle = '0;
  assign out_x             = x_q;
  assign out_y             = y_q;
  assign out_mode          = mode_q;
  assign out_done          = done_q;
  assign out_quadrant      = quad_q;

endmodule
